// File: rtl/dog_pkg.sv
//==============================================================================
// Module      : dog_pkg
// Description : Shared types and defaults for the DoG frame sequencer.
//               The border flag field is present only when
//               DOG_STREAM_BORDER_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dog_pkg;

    // Default frame geometry.
    localparam int IMG_W_DEF    = 640;
    localparam int IMG_H_DEF    = 480;
    // The DoG subtractor has a single register stage.
    localparam int PIPE_LAT_DEF = 1;
    localparam int BORDER_DEF   = 2;

    // Coordinate fields in the side-band are sized for the largest supported frame.
    localparam int COORD_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Side-band that travels alongside the DoG datapath.
    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               sof;
        logic               eol;
        logic               eof;
`ifdef DOG_STREAM_BORDER_EN
        logic               border;
`endif
    } sideband_t;

endpackage

`default_nettype wire

// File: rtl/dog_delay_line.sv
//==============================================================================
// Module      : dog_delay_line
// Description : Fixed-depth shift register with asynchronous active-low clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dog_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage_q;

    // Shift one stage per clock; stage 0 takes the new input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stage_q <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_stage_q[i] <= r_stage_q[i-1];
            end
            r_stage_q[0] <= d_i;
        end
    end

    assign q_o = r_stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/dog_stream_ctrl.sv
//==============================================================================
// Module      : dog_stream_ctrl
// Description : Frame sequencer for the DoG stage. Tracks pixel position,
//               generates framing/border markers aligned to the DoG output
//               and runs a start/busy/done handshake per frame.
//               Optional feature macro: DOG_STREAM_BORDER_EN (border flag).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dog_stream_ctrl
    import dog_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int BORDER   = BORDER_DEF
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     istart,
    input  logic                     ipix_valid,
    output logic                     odog_valid,
    output logic [$clog2(IMG_W)-1:0] ox,
    output logic [$clog2(IMG_H)-1:0] oy,
    output logic                     osof,
    output logic                     oeol,
    output logic                     oeof,
    output logic                     oborder,
    output logic                     obusy,
    output logic                     odone,
    output logic                     oerr
);

    localparam int c_XW = $clog2(IMG_W);
    localparam int c_YW = $clog2(IMG_H);
    localparam int c_FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [c_XW-1:0] c_X_LAST  = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST  = c_YW'(IMG_H - 1);
    localparam logic [c_FW-1:0] c_FL_LAST = c_FW'(PIPE_LAT - 1);

    state_t          r_state_q, w_state_d;
    logic [c_XW-1:0] r_x_q, w_x_d;
    logic [c_YW-1:0] r_y_q, w_y_d;
    logic [c_FW-1:0] r_flush_q, w_flush_d;
    logic            r_err_q, w_err_d;

    logic            w_accept;
    logic            w_x_last;
    logic            w_y_last;
    sideband_t       w_sb_in;
    sideband_t       w_sb_out;

    assign w_accept = (r_state_q == RUN) && ipix_valid;
    assign w_x_last = (r_x_q == c_X_LAST);
    assign w_y_last = (r_y_q == c_Y_LAST);

    // State, position, flush counter and sticky error registers.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state_q <= IDLE;
            r_x_q     <= '0;
            r_y_q     <= '0;
            r_flush_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_x_q     <= w_x_d;
            r_y_q     <= w_y_d;
            r_flush_q <= w_flush_d;
            r_err_q   <= w_err_d;
        end
    end

    // Next-state logic: frame walk in RUN, latency drain in FLUSH, one-cycle DONE.
    always_comb begin
        w_state_d = r_state_q;
        w_x_d     = r_x_q;
        w_y_d     = r_y_q;
        w_flush_d = r_flush_q;
        // Any pixel strobe outside RUN is a protocol error and is not counted.
        w_err_d   = r_err_q | (ipix_valid && (r_state_q != RUN));

        case (r_state_q)
            IDLE: begin
                w_x_d     = '0;
                w_y_d     = '0;
                w_flush_d = '0;
                if (istart) begin
                    w_err_d   = 1'b0;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                if (w_accept) begin
                    if (w_x_last) begin
                        w_x_d = '0;
                        if (w_y_last) begin
                            w_y_d     = '0;
                            w_state_d = FLUSH;
                        end else begin
                            w_y_d = r_y_q + c_YW'(1);
                        end
                    end else begin
                        w_x_d = r_x_q + c_XW'(1);
                    end
                end
            end
            FLUSH: begin
                if (r_flush_q == c_FL_LAST) begin
                    w_flush_d = '0;
                    w_state_d = DONE;
                end else begin
                    w_flush_d = r_flush_q + c_FW'(1);
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Markers from the pre-increment position; all-zero when no pixel is accepted.
    always_comb begin
        w_sb_in = '0;
        if (w_accept) begin
            w_sb_in.valid  = 1'b1;
            w_sb_in.x      = COORD_W'(r_x_q);
            w_sb_in.y      = COORD_W'(r_y_q);
            w_sb_in.sof    = (r_x_q == '0) && (r_y_q == '0);
            w_sb_in.eol    = w_x_last;
            w_sb_in.eof    = w_x_last && w_y_last;
`ifdef DOG_STREAM_BORDER_EN
            w_sb_in.border = (int'(r_x_q) < BORDER) ||
                             (int'(r_x_q) >= IMG_W - BORDER) ||
                             (int'(r_y_q) < BORDER) ||
                             (int'(r_y_q) >= IMG_H - BORDER);
`endif
        end
    end

    dog_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH ($bits(sideband_t))
    ) u_delay (
        .clk_i  (iclk),
        .rst_ni (irst_n),
        .d_i    (w_sb_in),
        .q_o    (w_sb_out)
    );

    // Side-band is stored as zero when invalid, so the markers are already qualified.
    assign odog_valid = w_sb_out.valid;
    assign ox         = w_sb_out.x[c_XW-1:0];
    assign oy         = w_sb_out.y[c_YW-1:0];
    assign osof       = w_sb_out.sof;
    assign oeol       = w_sb_out.eol;
    assign oeof       = w_sb_out.eof;
`ifdef DOG_STREAM_BORDER_EN
    assign oborder    = w_sb_out.border;
`else
    assign oborder    = 1'b0;
    localparam int c_unused_border = BORDER;
`endif

    assign obusy = (r_state_q == RUN) || (r_state_q == FLUSH);
    assign odone = (r_state_q == DONE);
    assign oerr  = r_err_q;

    // Upper coordinate bits are always zero; they exist only to fit the shared struct.
    logic w_unused_hi;
    assign w_unused_hi = ^{w_sb_out.x[COORD_W-1:c_XW], w_sb_out.y[COORD_W-1:c_YW]};

endmodule

`default_nettype wire

// File: tb/tb_dog_stream_ctrl.sv
`timescale 1ns/1ps
module tb_dog_stream_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 1;
    localparam int B = 1;
`ifdef DOG_STREAM_BORDER_EN
    localparam bit BEN = 1'b1;
`else
    localparam bit BEN = 1'b0;
`endif

    logic       iclk = 1'b0;
    logic       irst_n;
    logic       istart;
    logic       ipix_valid;
    logic       odog_valid;
    logic [1:0] ox;
    logic [1:0] oy;
    logic       osof, oeol, oeof, oborder, obusy, odone, oerr;

    dog_stream_ctrl #(
        .IMG_W(W), .IMG_H(H), .PIPE_LAT(L), .BORDER(B)
    ) dut (
        .iclk(iclk), .irst_n(irst_n), .istart(istart), .ipix_valid(ipix_valid),
        .odog_valid(odog_valid), .ox(ox), .oy(oy), .osof(osof), .oeol(oeol),
        .oeof(oeof), .oborder(oborder), .obusy(obusy), .odone(odone), .oerr(oerr)
    );

    always #5 iclk = ~iclk;

    int errors = 0;
    int checks = 0;
    int tb_cyc = 0;
    always @(posedge iclk) tb_cyc <= tb_cyc + 1;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v; int x; int y; bit sof; bit eol; bit eof; bit bord;
    } ent_t;

    ent_t hist[$];
    bit   m_active = 0;
    bit   m_err = 0;
    int   m_n = 0;
    int   m_last = -1;
    int   m_c = 0;
    ent_t e_out = '{default: 0};
    bit   e_busy = 0, e_done = 0, e_err = 0;

    // Model: pixel index n maps to (n%W, n/W); handshake timing is derived
    // from the cycle in which the last pixel was accepted.
    initial begin
        ent_t z, ne;
        bit   run;
        z = '{default: 0};
        forever begin
            @(posedge iclk or negedge irst_n);
            if (!irst_n) begin
                m_active = 0; m_err = 0; m_n = 0; m_last = -1; m_c = 0;
                hist.delete();
                e_out = z; e_busy = 0; e_done = 0; e_err = 0;
            end else begin
                run = m_active && (m_last < 0);
                ne  = z;
                if (run && ipix_valid) begin
                    ne.v    = 1;
                    ne.x    = m_n % W;
                    ne.y    = m_n / W;
                    ne.sof  = (m_n == 0);
                    ne.eol  = (ne.x == W - 1);
                    ne.eof  = (m_n == W * H - 1);
                    ne.bord = BEN && (ne.x < B || ne.x >= W - B || ne.y < B || ne.y >= H - B);
                    m_n++;
                    if (m_n == W * H) m_last = m_c;
                end
                if (istart && !m_active) begin
                    m_active = 1; m_n = 0; m_last = -1; m_err = 0;
                end else if (ipix_valid && !run) begin
                    m_err = 1;
                end
                hist.push_back(ne);
                if (hist.size() > L) void'(hist.pop_front());
                e_out = (hist.size() == L) ? hist[0] : z;
                m_c++;
                e_busy = m_active && (m_last < 0 || m_c <= m_last + L);
                e_done = m_active && (m_last >= 0) && (m_c == m_last + L + 1);
                if (m_active && m_last >= 0 && m_c == m_last + L + 2) m_active = 0;
                e_err = m_err;
            end
        end
    end

    // ---------------- observation log ----------------
    typedef struct { int x; int y; bit sof; bit eol; bit eof; bit bord; } obs_t;
    obs_t log_q[$];
    int   done_cnt = 0;
    int   done_cyc = -1;

    function automatic obs_t get_obs(input int i);
        obs_t o;
        o = '{default: 0};
        if (i < log_q.size()) o = log_q[i];
        return o;
    endfunction

    // Single compare process: every cycle, all outputs against the model.
    initial begin
        logic [12:0] act, exp;
        forever begin
            @(negedge iclk);
            act = {odog_valid, ox, oy, osof, oeol, oeof, oborder, obusy, odone, oerr};
            exp = {e_out.v, 2'(e_out.x), 2'(e_out.y), e_out.sof, e_out.eol, e_out.eof,
                   e_out.bord, e_busy, e_done, e_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_compare cyc=%0d got {v,x,y,sof,eol,eof,bord,busy,done,err}=%b required %b",
                         tb_cyc, act, exp);
            end
            if (odog_valid === 1'b1)
                log_q.push_back('{int'(ox), int'(oy), osof, oeol, oeof, oborder});
            if (odone === 1'b1) begin
                done_cnt++;
                done_cyc = tb_cyc;
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic st, input logic pv);
        @(posedge iclk);
        #1;
        istart     = st;
        ipix_valid = pv;
    endtask

    task automatic run_frame(input bit gated, output int last_in);
        last_in = 0;
        drive(1, 0);
        for (int i = 0; i < W * H; i++) begin
            drive(0, 1);
            last_in = tb_cyc;
            if (gated) drive(0, 0);
        end
        repeat (4) drive(0, 0);
    endtask

    function automatic int count_border();
        int n;
        n = 0;
        foreach (log_q[i]) if (log_q[i].bord) n++;
        return n;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int last_in;
        obs_t o;
        irst_n = 1'b0; istart = 1'b0; ipix_valid = 1'b0;
        repeat (2) @(posedge iclk);
        #1 irst_n = 1'b1;
        chk("reset_valid", odog_valid, 0);
        chk("reset_busy", obusy, 0);
        chk("reset_err", oerr, 0);

        // Continuous frame.
        log_q.delete(); done_cnt = 0;
        run_frame(0, last_in);
        chk("t1_pulses", log_q.size(), 12);
        o = get_obs(0);  chk("t1_sof_first", o.sof, 1);
        o = get_obs(3);  chk("t1_eol_4", o.eol, 1);
        o = get_obs(7);  chk("t1_eol_8", o.eol, 1);
        o = get_obs(11); chk("t1_eof_12", o.eof, 1);
        chk("t1_last_xy", o.x * 10 + o.y, 32);
        o = get_obs(6);  chk("t1_xy_7th", o.x * 10 + o.y, 21);
        chk("t1_done_lat", done_cyc - last_in, 2);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_border_cnt", count_border(), BEN ? 10 : 0);
        o = get_obs(5);  chk("t1_interior_11", o.bord, 0);
        o = get_obs(4);  chk("t1_border_01", o.bord, BEN ? 1 : 0);

        // Gated frame: same coordinates, gaps on the output.
        log_q.delete(); done_cnt = 0;
        run_frame(1, last_in);
        chk("t2_pulses", log_q.size(), 12);
        o = get_obs(5);  chk("t2_xy_6th", o.x * 10 + o.y, 11);
        o = get_obs(11); chk("t2_eof", o.eof, 1);
        chk("t2_done_cnt", done_cnt, 1);

        // Pixel strobe in IDLE: sticky error, cleared by the next start.
        drive(0, 1);
        drive(0, 0);
        drive(0, 0);
        chk("t3_err_sticky", oerr, 1);
        log_q.delete(); done_cnt = 0;
        drive(1, 0);
        drive(0, 1);
        chk("t3_err_cleared", oerr, 0);
        for (int i = 1; i < W * H; i++) drive(0, 1);
        repeat (4) drive(0, 0);
        chk("t3_pulses", log_q.size(), 12);
        o = get_obs(0);  chk("t3_first_sof", o.sof, 1);

        // Start during RUN at pixel 5 is ignored.
        log_q.delete(); done_cnt = 0;
        drive(1, 0);
        for (int i = 0; i < W * H; i++) drive((i == 5) ? 1'b1 : 1'b0, 1);
        repeat (4) drive(0, 0);
        chk("t4_pulses", log_q.size(), 12);
        o = get_obs(6);  chk("t4_xy_after", o.x * 10 + o.y, 21);
        chk("t4_done_cnt", done_cnt, 1);

        // Reset in the middle of a frame.
        log_q.delete(); done_cnt = 0;
        drive(1, 0);
        for (int i = 0; i < 6; i++) drive(0, 1);
        @(posedge iclk);
        #3 irst_n = 1'b0;
        istart = 1'b0; ipix_valid = 1'b0;
        #1;
        chk("t5_rst_busy", obusy, 0);
        chk("t5_rst_valid", odog_valid, 0);
        repeat (3) @(posedge iclk);
        #1 irst_n = 1'b1;
        repeat (4) drive(0, 0);
        chk("t5_no_done", done_cnt, 0);
        log_q.delete();
        run_frame(0, last_in);
        chk("t5_fresh_pulses", log_q.size(), 12);
        o = get_obs(0);  chk("t5_fresh_sof", o.sof * 100 + o.x * 10 + o.y, 100);

        // Randomized traffic: gaps, stray starts, stray pixels.
        for (int i = 0; i < 3000; i++) begin
            logic st, pv;
            st = ($urandom_range(0, 7) == 0);
            pv = st ? 1'b0 : ($urandom_range(0, 2) != 0);
            drive(st, pv);
        end
        repeat (6) drive(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
